stopwatch_ctrl: RTL and testbench

Control front end for the stopwatch counter/display stage. Synchronises and debounces two raw push-buttons, START/STOP and LAP/CLEAR, and turns clean presses into counter control: count enable, synchronous clear pulse and display freeze. Sits directly upstream of the digit counter and 7-segment mux, which consume CNT_EN, CNT_CLR and DISP_FREEZE.

---
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: button sync/debounce and run/pause/clear FSM.
// Define STOPWATCH_LAP_HOLD_EN to build the LAP (display freeze) state.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_SS,
  input  logic       BTN_LC,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       DISP_FREEZE,
  output logic [1:0] STATE
);

  // state | meaning
  // IDLE  | stopped, counter at zero or cleared
  // RUN   | counting, display live
  // PAUSE | stopped, value held in counter
  // LAP   | counting, display frozen
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // index 0 = START/STOP, index 1 = LAP/CLEAR
  logic [1:0]       btn_meta;
  logic [1:0]       btn_sync;
  logic [1:0]       btn_stable;
  logic [1:0]       btn_press;
  logic [DEB_W-1:0] deb_cnt [2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_meta <= 2'b00;
      btn_sync <= 2'b00;
    end else begin
      btn_meta <= {BTN_LC, BTN_SS};
      btn_sync <= btn_meta;
    end
  end

  // Press pulse is raised on the same edge that accepts a new high level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_stable <= 2'b00;
      btn_press  <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_sync[i] == btn_stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]    <= '0;
          btn_stable[i] <= btn_sync[i];
          btn_press[i]  <= btn_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  logic   ss_press;
  logic   lc_press;
  state_t state;
  logic   cnt_en;
  logic   cnt_clr;

  assign ss_press = btn_press[0];
  assign lc_press = btn_press[1];

`ifdef STOPWATCH_LAP_HOLD_EN
  logic disp_freeze;
`endif

  // SS is tested first everywhere so a simultaneous LC press is dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
      disp_freeze <= 1'b0;
`endif
    end else begin
      cnt_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_press) begin
            state  <= RUN;
            cnt_en <= 1'b1;
          end else if (lc_press) begin
            cnt_clr <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            state  <= PAUSE;
            cnt_en <= 1'b0;
          end
`ifdef STOPWATCH_LAP_HOLD_EN
          else if (lc_press) begin
            state       <= LAP;
            disp_freeze <= 1'b1;
          end
`endif
        end
        PAUSE: begin
          if (ss_press) begin
            state  <= RUN;
            cnt_en <= 1'b1;
          end else if (lc_press) begin
            state   <= IDLE;
            cnt_clr <= 1'b1;
          end
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        LAP: begin
          if (ss_press) begin
            state       <= PAUSE;
            cnt_en      <= 1'b0;
            disp_freeze <= 1'b0;
          end else if (lc_press) begin
            state       <= RUN;
            disp_freeze <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          cnt_en <= 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
          disp_freeze <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign CNT_EN  = cnt_en;
  assign CNT_CLR = cnt_clr;
  assign STATE   = state;
`ifdef STOPWATCH_LAP_HOLD_EN
  assign DISP_FREEZE = disp_freeze;
`else
  assign DISP_FREEZE = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES = 4.
// Expected values are hand-derived from the button timing below.
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_SS = 1'b0;
  logic       BTN_LC = 1'b0;
  logic       CNT_EN;
  logic       CNT_CLR;
  logic       DISP_FREEZE;
  logic [1:0] STATE;

  int n_cmp = 0;
  int n_err = 0;
  int excl_viol = 0;

  stopwatch_ctrl #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BTN_SS(BTN_SS),
    .BTN_LC(BTN_LC),
    .CNT_EN(CNT_EN),
    .CNT_CLR(CNT_CLR),
    .DISP_FREEZE(DISP_FREEZE),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (!RESET && CNT_CLR === 1'b1 && CNT_EN === 1'b1) excl_viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Runs n cycles, counting CNT_CLR high cycles and the first one seen.
  task automatic watch(input int n, output int clr_n, output int clr_at);
    clr_n = 0;
    clr_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      if (CNT_CLR === 1'b1) begin
        clr_n++;
        if (clr_at < 0) clr_at = i;
      end
    end
  endtask

  task automatic press(input logic ss, input logic lc);
    BTN_SS = ss;
    BTN_LC = lc;
    tick(10);
    BTN_SS = 1'b0;
    BTN_LC = 1'b0;
    tick(10);
  endtask

  initial begin
    int c_n, c_at, c_n2, c_at2;

    tick(2);
    chk("rst_state", STATE, 2'b00);
    chk("rst_en", CNT_EN, 0);
    chk("rst_clr", CNT_CLR, 0);
    chk("rst_freeze", DISP_FREEZE, 0);
    RESET = 1'b0;
    tick(3);
    chk("idle_state", STATE, 2'b00);

    // 3-cycle LC glitch never reaches DEB_CYCLES
    BTN_LC = 1'b1;
    watch(3, c_n, c_at);
    BTN_LC = 1'b0;
    watch(12, c_n2, c_at2);
    chk("glitch_clr", c_n + c_n2, 0);
    chk("glitch_state", STATE, 2'b00);

    // SS bounce 1,0,1 then steady: CNT_EN rises on the 7th edge after the steady edge
    BTN_SS = 1'b1; tick(1);
    BTN_SS = 1'b0; tick(1);
    BTN_SS = 1'b1; tick(6);
    chk("ss_lat_early_en", CNT_EN, 0);
    chk("ss_lat_early_state", STATE, 2'b00);
    tick(1);
    chk("ss_lat_en", CNT_EN, 1);
    chk("ss_lat_state", STATE, 2'b01);
    tick(3);
    BTN_SS = 1'b0;
    tick(10);
    chk("ss_hold_once", STATE, 2'b01);

    // LC in RUN
    press(1'b0, 1'b1);
`ifdef STOPWATCH_LAP_HOLD_EN
    chk("lap_state", STATE, 2'b11);
    chk("lap_en", CNT_EN, 1);
    chk("lap_freeze", DISP_FREEZE, 1);
    press(1'b0, 1'b1);
    chk("unlap_state", STATE, 2'b01);
    chk("unlap_freeze", DISP_FREEZE, 0);
`else
    chk("nolap_state", STATE, 2'b01);
    chk("nolap_freeze", DISP_FREEZE, 0);
    chk("nolap_en", CNT_EN, 1);
`endif

    // RUN -> PAUSE
    press(1'b1, 1'b0);
    chk("pause_state", STATE, 2'b10);
    chk("pause_en", CNT_EN, 0);

    // PAUSE, LC -> single clear pulse 7 cycles after the raw edge, back to IDLE
    BTN_LC = 1'b1;
    watch(10, c_n, c_at);
    chk("pclr_count", c_n, 1);
    chk("pclr_at", c_at, 7);
    chk("pclr_state", STATE, 2'b00);
    BTN_LC = 1'b0;
    watch(10, c_n, c_at);
    chk("pclr_release", c_n, 0);

    // IDLE, LC -> clear pulse, stay IDLE
    BTN_LC = 1'b1;
    watch(10, c_n, c_at);
    BTN_LC = 1'b0;
    watch(10, c_n2, c_at2);
    chk("iclr_count", c_n + c_n2, 1);
    chk("iclr_state", STATE, 2'b00);

    // IDLE -> RUN -> PAUSE, then simultaneous press: SS wins
    press(1'b1, 1'b0);
    chk("resume_run", STATE, 2'b01);
    press(1'b1, 1'b0);
    chk("to_pause", STATE, 2'b10);
    BTN_SS = 1'b1;
    BTN_LC = 1'b1;
    watch(10, c_n, c_at);
    BTN_SS = 1'b0;
    BTN_LC = 1'b0;
    watch(10, c_n2, c_at2);
    chk("simul_clr", c_n + c_n2, 0);
    chk("simul_state", STATE, 2'b01);
    chk("simul_en", CNT_EN, 1);

    // asynchronous reset while running, away from any clock edge
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_en", CNT_EN, 0);
    chk("async_rst_state", STATE, 2'b00);
    tick(1);
    RESET = 1'b0;

    // reset in the middle of a debounce leaves no residual press
    BTN_SS = 1'b1;
    tick(4);
    RESET = 1'b1;
    tick(1);
    BTN_SS = 1'b0;
    tick(1);
    RESET = 1'b0;
    watch(12, c_n, c_at);
    chk("middeb_state", STATE, 2'b00);
    chk("middeb_en", CNT_EN, 0);

    // button held through reset release debounces to one press
    BTN_SS = 1'b1;
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(6);
    chk("held_early", STATE, 2'b00);
    tick(1);
    chk("held_state", STATE, 2'b01);
    tick(10);
    BTN_SS = 1'b0;
    tick(10);
    chk("held_once", STATE, 2'b01);

    chk("clr_en_exclusive", excl_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
